// File: rtl/reflet_float_mult_round.sv
// Normalize / round / pack stage of the FPU multiply path, two-entry valid/ready pipeline.
// Define REFLET_FLOAT_ROUND_EN for round-to-nearest-even; otherwise results are truncated.
module reflet_float_mult_round #(
    parameter int unsigned float_size = 16,
    parameter int unsigned exp_size   = 5
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [2*(float_size-exp_size-1)+1:0]  in_prod,
    input  logic [exp_size-1:0]                   in_exp_a,
    input  logic [exp_size-1:0]                   in_exp_b,
    input  logic                                  in_sign,
    input  logic                                  in_zero,
    input  logic                                  in_inf,
    input  logic                                  in_nan,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [float_size-1:0]                 out_result,
    output logic                                  out_overflow,
    output logic                                  out_underflow
);
    localparam int unsigned M      = float_size - exp_size - 1;
    localparam int unsigned EW     = exp_size + 2;
    localparam int unsigned Bias   = 2**(exp_size-1) - 1;
    localparam int unsigned MaxExp = 2**exp_size - 1;

    logic          s2_adv, s1_adv;
    logic          s1_valid_q, s1_valid_d;
    logic [M-1:0]  s1_mant_q, s1_mant_d;
    logic [EW-1:0] s1_e_q, s1_e_d;
    logic          s1_sign_q, s1_sign_d;
    logic          s1_zero_q, s1_zero_d;
    logic          s1_inf_q, s1_inf_d;
    logic          s1_nan_q, s1_nan_d;
`ifdef REFLET_FLOAT_ROUND_EN
    logic          s1_guard_q, s1_guard_d;
    logic          s1_sticky_q, s1_sticky_d;
    logic [M:0]    mant_sum;
`else
    logic          unused_lsbs;
    assign unused_lsbs = ^in_prod[M-1:0];
`endif

    logic [M-1:0]          mant_r;
    logic [EW-1:0]         e_r;
    logic                  ovf, unf;
    logic [float_size-1:0] res_c;
    logic                  ovf_c, unf_c;

    logic                  out_valid_q, out_valid_d;
    logic [float_size-1:0] out_result_q, out_result_d;
    logic                  out_overflow_q, out_overflow_d;
    logic                  out_underflow_q, out_underflow_d;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mant_d  = s1_mant_q;
        s1_e_d     = s1_e_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_inf_d   = s1_inf_q;
        s1_nan_d   = s1_nan_q;
`ifdef REFLET_FLOAT_ROUND_EN
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
`endif
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (s1_adv && in_valid) begin
            s1_e_d    = EW'(in_exp_a) + EW'(in_exp_b) - EW'(Bias);
            s1_sign_d = in_sign;
            s1_zero_d = in_zero;
            s1_inf_d  = in_inf;
            s1_nan_d  = in_nan;
            // Product in [1,4): top bit set means shift right by one.
            if (in_prod[2*M+1]) begin
                s1_mant_d = in_prod[2*M:M+1];
                s1_e_d    = s1_e_d + EW'(1);
`ifdef REFLET_FLOAT_ROUND_EN
                s1_guard_d  = in_prod[M];
                s1_sticky_d = |in_prod[M-1:0];
`endif
            end else begin
                s1_mant_d = in_prod[2*M-1:M];
`ifdef REFLET_FLOAT_ROUND_EN
                s1_guard_d  = in_prod[M-1];
                s1_sticky_d = |in_prod[M-2:0];
`endif
            end
        end
    end

    always_comb begin
        mant_r = s1_mant_q;
        e_r    = s1_e_q;
`ifdef REFLET_FLOAT_ROUND_EN
        mant_sum = {1'b0, s1_mant_q} + (M+1)'(s1_guard_q & (s1_sticky_q | s1_mant_q[0]));
        mant_r   = mant_sum[M-1:0];
        if (mant_sum[M]) begin
            e_r = s1_e_q + EW'(1);
        end
`endif
        ovf = !e_r[EW-1] && (e_r >= EW'(MaxExp));
        unf = e_r[EW-1] || (e_r == '0);

        ovf_c = 1'b0;
        unf_c = 1'b0;
        if (s1_nan_q) begin
            res_c = {1'b0, {exp_size{1'b1}}, 1'b1, {(M-1){1'b0}}};
        end else if (s1_inf_q) begin
            res_c = {s1_sign_q, {exp_size{1'b1}}, {M{1'b0}}};
        end else if (s1_zero_q) begin
            res_c = {s1_sign_q, {(float_size-1){1'b0}}};
        end else if (ovf) begin
            res_c = {s1_sign_q, {exp_size{1'b1}}, {M{1'b0}}};
            ovf_c = 1'b1;
        end else if (unf) begin
            res_c = {s1_sign_q, {(float_size-1){1'b0}}};
            unf_c = 1'b1;
        end else begin
            res_c = {s1_sign_q, e_r[exp_size-1:0], mant_r};
        end
    end

    always_comb begin
        out_valid_d     = out_valid_q;
        out_result_d    = out_result_q;
        out_overflow_d  = out_overflow_q;
        out_underflow_d = out_underflow_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
        end
        if (s2_adv && s1_valid_q) begin
            out_result_d    = res_c;
            out_overflow_d  = ovf_c;
            out_underflow_d = unf_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q      <= 1'b0;
            s1_mant_q       <= '0;
            s1_e_q          <= '0;
            s1_sign_q       <= 1'b0;
            s1_zero_q       <= 1'b0;
            s1_inf_q        <= 1'b0;
            s1_nan_q        <= 1'b0;
`ifdef REFLET_FLOAT_ROUND_EN
            s1_guard_q      <= 1'b0;
            s1_sticky_q     <= 1'b0;
`endif
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_overflow_q  <= 1'b0;
            out_underflow_q <= 1'b0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_mant_q       <= s1_mant_d;
            s1_e_q          <= s1_e_d;
            s1_sign_q       <= s1_sign_d;
            s1_zero_q       <= s1_zero_d;
            s1_inf_q        <= s1_inf_d;
            s1_nan_q        <= s1_nan_d;
`ifdef REFLET_FLOAT_ROUND_EN
            s1_guard_q      <= s1_guard_d;
            s1_sticky_q     <= s1_sticky_d;
`endif
            out_valid_q     <= out_valid_d;
            out_result_q    <= out_result_d;
            out_overflow_q  <= out_overflow_d;
            out_underflow_q <= out_underflow_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_overflow  = out_overflow_q;
    assign out_underflow = out_underflow_q;

endmodule

// File: tb/tb_reflet_float_mult_round.sv
// Directed self-checking bench for reflet_float_mult_round (float16 defaults).
module tb_reflet_float_mult_round;

`ifdef REFLET_FLOAT_ROUND_EN
    localparam bit RN = 1'b1;
`else
    localparam bit RN = 1'b0;
`endif

    typedef struct packed {
        logic [21:0] prod;
        logic [4:0]  ea;
        logic [4:0]  eb;
        logic        sign;
        logic        z;
        logic        i;
        logic        n;
        logic [15:0] res;
        logic        ov;
        logic        un;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [21:0] in_prod = '0;
    logic [4:0]  in_exp_a = '0;
    logic [4:0]  in_exp_b = '0;
    logic        in_sign = 1'b0;
    logic        in_zero = 1'b0;
    logic        in_inf = 1'b0;
    logic        in_nan = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic        out_overflow;
    logic        out_underflow;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reflet_float_mult_round dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_prod      (in_prod),
        .in_exp_a     (in_exp_a),
        .in_exp_b     (in_exp_b),
        .in_sign      (in_sign),
        .in_zero      (in_zero),
        .in_inf       (in_inf),
        .in_nan       (in_nan),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow)
    );

    task automatic present(input vec_t v);
        in_valid = 1'b1;
        in_prod  = v.prod;
        in_exp_a = v.ea;
        in_exp_b = v.eb;
        in_sign  = v.sign;
        in_zero  = v.z;
        in_inf   = v.i;
        in_nan   = v.n;
    endtask

    // Sends one beat into an empty pipe; lat counts edges from the accepting edge to out_valid.
    task automatic run_beat(input vec_t v, output logic [15:0] res, output logic [1:0] flags,
                            output int lat);
        out_ready = 1'b1;
        present(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        res   = out_result;
        flags = {out_overflow, out_underflow};
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({out_valid, out_result, out_overflow, out_underflow} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b r=%h o=%b u=%b want all 0",
                     out_valid, out_result, out_overflow, out_underflow);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_rounding();
        vec_t v[7];
        logic [15:0] res;
        logic [1:0] fl;
        int lat;
        v[0] = '{22'h100000, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3C00, 1'b0, 1'b0};
        v[1] = '{22'h240000, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4080, 1'b0, 1'b0};
        v[2] = '{22'h180600, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0,
                 RN ? 16'h3E02 : 16'h3E01, 1'b0, 1'b0};
        v[3] = '{22'h180200, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3E00, 1'b0, 1'b0};
        v[4] = '{22'h180201, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0,
                 RN ? 16'h3E01 : 16'h3E00, 1'b0, 1'b0};
        v[5] = '{22'h1FFE00, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0,
                 RN ? 16'h4000 : 16'h3FFF, 1'b0, 1'b0};
        v[6] = '{22'h100000, 5'd15, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 16'hBC00, 1'b0, 1'b0};
        for (int k = 0; k < 7; k++) begin
            run_beat(v[k], res, fl, lat);
            n_checks++;
            if (lat !== 2) begin
                n_fail++;
                $display("FAIL round_latency[%0d] got %0d want 2", k, lat);
            end
            n_checks++;
            if (res !== v[k].res || fl !== {v[k].ov, v[k].un}) begin
                n_fail++;
                $display("FAIL round[%0d] got %h flags %b want %h flags %b",
                         k, res, fl, v[k].res, {v[k].ov, v[k].un});
            end
        end
    endtask

    task automatic test_range();
        vec_t v[7];
        logic [15:0] res;
        logic [1:0] fl;
        int lat;
        v[0] = '{22'h100000, 5'd30, 5'd30, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7C00, 1'b1, 1'b0};
        v[1] = '{22'h100000, 5'd30, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7800, 1'b0, 1'b0};
        v[2] = '{22'h100000, 5'd30, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFC00, 1'b1, 1'b0};
        v[3] = '{22'h100000, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        v[4] = '{22'h100000, 5'd8, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0400, 1'b0, 1'b0};
        v[5] = '{22'h100000, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        v[6] = '{22'h1FFE00, 5'd30, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0,
                 RN ? 16'h7C00 : 16'h7BFF, RN, 1'b0};
        for (int k = 0; k < 7; k++) begin
            run_beat(v[k], res, fl, lat);
            n_checks++;
            if (lat !== 2 || res !== v[k].res || fl !== {v[k].ov, v[k].un}) begin
                n_fail++;
                $display("FAIL range[%0d] got %h flags %b lat %0d want %h flags %b lat 2",
                         k, res, fl, lat, v[k].res, {v[k].ov, v[k].un});
            end
        end
    endtask

    task automatic test_special();
        vec_t v[5];
        logic [15:0] res;
        logic [1:0] fl;
        int lat;
        v[0] = '{22'h100000, 5'd15, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1, 16'h7E00, 1'b0, 1'b0};
        v[1] = '{22'h100000, 5'd15, 5'd15, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFC00, 1'b0, 1'b0};
        v[2] = '{22'h100000, 5'd30, 5'd30, 1'b1, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0};
        v[3] = '{22'h100000, 5'd15, 5'd15, 1'b0, 1'b1, 1'b1, 1'b1, 16'h7E00, 1'b0, 1'b0};
        v[4] = '{22'h100000, 5'd1, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h7C00, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            run_beat(v[k], res, fl, lat);
            n_checks++;
            if (lat !== 2 || res !== v[k].res || fl !== {v[k].ov, v[k].un}) begin
                n_fail++;
                $display("FAIL special[%0d] got %h flags %b lat %0d want %h flags %b lat 2",
                         k, res, fl, lat, v[k].res, {v[k].ov, v[k].un});
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[3];
        v[0] = '{22'h100000, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3C00, 1'b0, 1'b0};
        v[1] = '{22'h240000, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4080, 1'b0, 1'b0};
        v[2] = '{22'h100000, 5'd30, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 16'hF800, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                present(v[c]);
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready[%0d] got %b want 1", c, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (c >= 1 && c <= 3) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_result !== v[c-1].res) begin
                    n_fail++;
                    $display("FAIL b2b_out[%0d] got v=%b %h want v=1 %h",
                             c - 1, out_valid, out_result, v[c-1].res);
                end
            end else if (c == 4) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_drain got out_valid %b want 0", out_valid);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        vec_t a, b, c;
        a = '{22'h100000, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3C00, 1'b0, 1'b0};
        b = '{22'h240000, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4080, 1'b0, 1'b0};
        c = '{22'h100000, 5'd30, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7800, 1'b0, 1'b0};
        out_ready = 1'b0;
        present(a); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept_a got in_ready %b want 1", in_ready);
        end
        @(posedge clk); #1;
        present(b);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept_b got in_ready %b want 1", in_ready);
        end
        @(posedge clk); #1;
        present(c);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== a.res) begin
            n_fail++;
            $display("FAIL bp_full got rdy=%b v=%b %h want rdy=0 v=1 %h",
                     in_ready, out_valid, out_result, a.res);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== a.res) begin
            n_fail++;
            $display("FAIL bp_hold got rdy=%b v=%b %h want rdy=0 v=1 %h",
                     in_ready, out_valid, out_result, a.res);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== b.res) begin
            n_fail++;
            $display("FAIL bp_second got v=%b %h want v=1 %h", out_valid, out_result, b.res);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== c.res) begin
            n_fail++;
            $display("FAIL bp_third got v=%b %h want v=1 %h", out_valid, out_result, c.res);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty got out_valid %b want 0", out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        vec_t a, b;
        logic [15:0] res;
        logic [1:0] fl;
        int lat;
        a = '{22'h240000, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4080, 1'b0, 1'b0};
        b = '{22'h100000, 5'd30, 5'd30, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7C00, 1'b1, 1'b0};
        out_ready = 1'b0;
        present(b);
        @(posedge clk); #1;
        present(b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_result, out_overflow, out_underflow} !== 19'd0 || in_ready !== 1'b1)
        begin
            n_fail++;
            $display("FAIL mid_reset got v=%b r=%h o=%b u=%b rdy=%b want 0/0/0/0/1",
                     out_valid, out_result, out_overflow, out_underflow, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_idle[%0d] got out_valid %b want 0", k, out_valid);
            end
        end
        @(negedge clk);
        run_beat(a, res, fl, lat);
        n_checks++;
        if (lat !== 2 || res !== a.res || fl !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_new got %h flags %b lat %0d want %h flags 00 lat 2",
                     res, fl, lat, a.res);
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_range();
        test_special();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
